// File: rtl/seg7_pkg.sv
// Shared 7-segment decode constants and helpers for display blocks.
// Patterns are active-high, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_BLANK = 7'b0000000;

    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        unique case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Width of a digit index; never below 1 so single-digit builds still have a port.
    function automatic int unsigned idx_width(input int unsigned num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the datapath (master) and the 7-segment scan driver (slave).
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IdxW = idx_width(NUM_DIGITS);

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic [IdxW-1:0]           digit_idx;

    modport master (
        output load, bcd_in, dp_in,
        input  seg, dp, an, digit_idx
    );

    modport slave (
        input  load, bcd_in, dp_in,
        output seg, dp, an, digit_idx
    );

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot divider and digit counter for the scan driver.
// Exposes next-state values so the caller's output registers line up with the count.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 50000,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DEAD_CYCLES = 1,
    localparam int unsigned CntW       = $clog2(CLK_DIV),
    localparam int unsigned IdxW       = idx_width(NUM_DIGITS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [IdxW-1:0] o_idx_next,
    output logic            o_live_next
);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [IdxW-1:0] r_idx;
    logic [IdxW-1:0] w_idx_d;

    always_comb begin
        w_cnt_d = r_cnt + 1'b1;
        w_idx_d = r_idx;
        if (r_cnt == CntMax) begin
            w_cnt_d = '0;
            w_idx_d = (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_d;
            r_idx <= w_idx_d;
        end
    end

    assign o_idx_next  = w_idx_d;
    assign o_live_next = 32'(w_cnt_d) >= DEAD_CYCLES;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow capture, leading-zero blanking,
// BCD decode and registered, polarity-adjusted pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned CLK_DIV         = 50000,
    parameter int unsigned DEAD_CYCLES     = 1,
    parameter bit          SEG_ACTIVE_HIGH = 1'b1,
    parameter bit          AN_ACTIVE_HIGH  = 1'b0,
    parameter bit          BLANK_LZ        = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned IdxW = idx_width(NUM_DIGITS);

    // XOR masks that turn an active-high view into pin levels; also the idle levels.
    localparam logic [6:0]            SegOff = {7{~SEG_ACTIVE_HIGH}};
    localparam logic                  DpOff  = ~SEG_ACTIVE_HIGH;
    localparam logic [NUM_DIGITS-1:0] AnOff  = {NUM_DIGITS{~AN_ACTIVE_HIGH}};

    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [IdxW-1:0]         w_idx_next;
    logic                    w_live_next;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_lz_run;
    logic [3:0]              w_digit;
    logic                    w_digit_dp;
    logic                    w_digit_blank;
    logic [6:0]              w_seg_ah;
    logic [NUM_DIGITS-1:0]   w_an_ah;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [IdxW-1:0]         r_idx;

    seg7_scan_timer #(
        .CLK_DIV    (CLK_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .o_idx_next (w_idx_next),
        .o_live_next(w_live_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd   <= '0;
            r_dp_sh <= '0;
        end else if (bus.load) begin
            r_bcd   <= bus.bcd_in;
            r_dp_sh <= bus.dp_in;
        end
    end

    // A run of zeros from the MSB is blanked; any invalid code or lit dp ends the run.
    always_comb begin
        w_lz_run = 1'b1;
        w_blank  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run   = w_lz_run & (r_bcd[4*i +: 4] == 4'd0) & ~r_dp_sh[i];
            w_blank[i] = w_lz_run & BLANK_LZ;
        end
    end

    always_comb begin
        w_digit       = '0;
        w_digit_dp    = 1'b0;
        w_digit_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_next == IdxW'(i)) begin
                w_digit       = r_bcd[4*i +: 4];
                w_digit_dp    = r_dp_sh[i];
                w_digit_blank = w_blank[i];
            end
        end
        w_seg_ah = w_digit_blank ? SEG_BLANK : bcd_to_seg(w_digit);
        w_an_ah  = w_live_next ? (NUM_DIGITS'(1) << w_idx_next) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SegOff;
            r_dp  <= DpOff;
            r_an  <= AnOff;
            r_idx <= '0;
        end else begin
            r_seg <= w_seg_ah ^ SegOff;
            r_dp  <= w_digit_dp ^ DpOff;
            r_an  <= w_an_ah ^ AnOff;
            r_idx <= w_idx_next;
        end
    end

    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.an        = r_an;
    assign bus.digit_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: NUM_DIGITS=4, CLK_DIV=4, DEAD_CYCLES=1.
module tb_seg7_scan_driver;

    localparam int ND   = 4;
    localparam int DIV  = 4;
    localparam int DEAD = 1;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [1:0] idx;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    out_t exp_q[$];

    // Reference state: divider/digit counters and shadow registers as the DUT should hold them.
    int          mc = 0;
    int          mi = 0;
    logic [15:0] sh_bcd = '0;
    logic [3:0]  sh_dp  = '0;

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (DIV),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Highest digit that is nonzero or carries a dp; everything above it (except 0) is blank.
    function automatic logic [6:0] exp_seg(input logic [15:0] b, input logic [3:0] d, input int i);
        int         top;
        logic [3:0] v;
        top = 0;
        for (int k = 0; k < ND; k++) if (b[4*k +: 4] != 4'd0 || d[k]) top = k;
        v = b[4*i +: 4];
        if (i > top || v > 4'd9) return 7'b0000000;
        return seg_tbl[v];
    endfunction

    task automatic cycle(input logic r, input logic ld, input logic [15:0] b, input logic [3:0] d);
        out_t e;
        int   nc;
        int   ni;
        rst          = r;
        bus.load     = ld;
        bus.bcd_in   = b;
        bus.dp_in    = d;
        if (r) begin
            e      = '{seg: 7'b0000000, dp: 1'b0, an: 4'b1111, idx: 2'd0};
            mc     = 0;
            mi     = 0;
            sh_bcd = '0;
            sh_dp  = '0;
        end else begin
            nc     = (mc == DIV - 1) ? 0 : mc + 1;
            ni     = (mc == DIV - 1) ? (mi + 1) % ND : mi;
            e.idx  = 2'(ni);
            e.an   = (nc >= DEAD) ? ~(4'b0001 << ni) : 4'b1111;
            e.seg  = exp_seg(sh_bcd, sh_dp, ni);
            e.dp   = sh_dp[ni];
            mc     = nc;
            mi     = ni;
            if (ld) begin
                sh_bcd = b;
                sh_dp  = d;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t e, got;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b0, 16'h0000, 4'h0);
            got = {bus.seg, bus.dp, bus.an, bus.digit_idx};
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.seg, got.dp, got.an, got.idx, e.seg, e.dp, e.an, e.idx);
            end
        end
    endtask

    task automatic test_count();
        out_t       e, got;
        logic [6:0] lit [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
        cycle(1'b0, 1'b1, 16'h1234, 4'h0);
        void'(exp_q.pop_front());
        for (int c = 0; c < 18; c++) begin
            cycle(1'b0, 1'b0, 16'h0000, 4'h0);
            got = {bus.seg, bus.dp, bus.an, bus.digit_idx};
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL count_1234 c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.seg, got.dp, got.an, got.idx, e.seg, e.dp, e.an, e.idx);
            end
            n_cmp++;
            if (got.seg !== lit[got.idx]) begin
                n_err++;
                $display("FAIL count_lit c%0d idx %0d: got seg %b want %b", c, got.idx,
                         got.seg, lit[got.idx]);
            end
        end
    endtask

    task automatic test_leading_zero();
        out_t        e, got;
        logic [15:0] vals [2] = '{16'h0042, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            cycle(1'b0, 1'b1, vals[v], 4'h0);
            for (int c = 0; c < 18; c++) begin
                if (c > 0) cycle(1'b0, 1'b0, 16'hFFFF, 4'hF);
                got = {bus.seg, bus.dp, bus.an, bus.digit_idx};
                e   = exp_q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL lz_%h c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", vals[v], c,
                             got.seg, got.dp, got.an, got.idx, e.seg, e.dp, e.an, e.idx);
                end
            end
        end
    endtask

    task automatic test_dp_and_invalid();
        out_t        e, got;
        logic [15:0] vals [2] = '{16'h0005, 16'h00A7};
        logic [3:0]  dps  [2] = '{4'b0010, 4'b0000};
        for (int v = 0; v < 2; v++) begin
            cycle(1'b0, 1'b1, vals[v], dps[v]);
            for (int c = 0; c < 18; c++) begin
                if (c > 0) cycle(1'b0, 1'b0, 16'h0000, 4'h0);
                got = {bus.seg, bus.dp, bus.an, bus.digit_idx};
                e   = exp_q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL dpinv_%h c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", vals[v], c,
                             got.seg, got.dp, got.an, got.idx, e.seg, e.dp, e.an, e.idx);
                end
            end
        end
    endtask

    task automatic test_mid_slot();
        out_t e, got;
        int   guard;
        guard = 0;
        while (mc != 2 && guard < 2 * DIV) begin
            cycle(1'b0, 1'b0, 16'h0000, 4'h0);
            void'(exp_q.pop_front());
            guard++;
        end
        n_cmp++;
        if (mc != 2) begin
            n_err++;
            $display("FAIL mid_align: got div %0d want 2", mc);
        end
        cycle(1'b0, 1'b1, 16'h9999, 4'h0);
        void'(exp_q.pop_front());
        for (int c = 0; c < 22; c++) begin
            cycle((c == 9) ? 1'b1 : 1'b0, 1'b0, 16'h0000, 4'h0);
            got = {bus.seg, bus.dp, bus.an, bus.digit_idx};
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL mid_9999_rst c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         got.seg, got.dp, got.an, got.idx, e.seg, e.dp, e.an, e.idx);
            end
            if (c == 0) begin
                n_cmp++;
                if (got.seg !== 7'b1111011) begin
                    n_err++;
                    $display("FAIL mid_first: got seg %b want 1111011", got.seg);
                end
            end
        end
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        test_reset();
        test_count();
        test_leading_zero();
        test_dp_and_invalid();
        test_mid_slot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
